fxdiv16by8_seq: RTL and testbench

FXDIV16BY8_SEQ -- requirements
Module: fxdiv16by8_seq

---
 rtl/fxdiv16by8_seq.sv | 118 +++++++++++
 tb/tb_fxdiv16by8_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fxdiv16by8_seq.sv
// fxdiv16by8_seq -- sequential 16-by-8 unsigned restoring divider.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division; only looked at in IDLE
//   dividend     16-bit unsigned dividend
//   divisor      8-bit unsigned divisor
//   busy         high in CALC and DONE
//   done         one-cycle pulse when the results are valid
//   quotient     8-bit quotient (ERR_QUOT on error)
//   remainder    8-bit remainder (0 on error)
//   div_by_zero  last operation had divisor == 0
//   overflow     last operation's quotient would not fit in 8 bits
//
// The quotient register doubles as the dividend low-byte shift register:
// each CALC step consumes its MSB as the next dividend bit and shifts the
// new quotient bit in at the LSB, so after 8 steps it holds the quotient.
module fxdiv16by8_seq #(
  parameter logic [7:0] ERR_QUOT = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [7:0]  quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [7:0]  dsr_r;
  logic [2:0]  cnt;
  logic        err_zero, err_ovf;
  logic [8:0]  t, diff;
  logic        ge;

  // A high byte >= divisor means the true quotient needs more than 8 bits.
  assign err_zero = (divisor == 8'h00);
  assign err_ovf  = !err_zero && (dividend[15:8] >= divisor);

  // One restoring step: bring in the next dividend bit, try to subtract.
  assign t    = {remainder, quotient[7]};
  assign ge   = (t >= {1'b0, dsr_r});
  assign diff = t - {1'b0, dsr_r};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (err_zero || err_ovf) ? DONE : CALC;
      CALC:    if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr_r       <= 8'h00;
      cnt         <= 3'd0;
      quotient    <= 8'h00;
      remainder   <= 8'h00;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dsr_r <= divisor;
          cnt   <= 3'd0;
          if (err_zero) begin
            quotient    <= ERR_QUOT;
            remainder   <= 8'h00;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (err_ovf) begin
            quotient    <= ERR_QUOT;
            remainder   <= 8'h00;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= dividend[7:0];
            remainder   <= dividend[15:8];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        CALC: begin
          // remainder < divisor keeps t < 2*divisor, so diff fits in 8 bits
          remainder <= ge ? diff[7:0] : t[7:0];
          quotient  <= {quotient[6:0], ge};
          cnt       <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxdiv16by8_seq.sv
// tb_fxdiv16by8_seq -- scoreboard bench for fxdiv16by8_seq.
// Stimulus pushes hand-computed results into a queue; a monitor pops and
// compares each time done is seen.
module tb_fxdiv16by8_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = 16'h0;
  logic [7:0]  divisor = 8'h0;
  logic        busy, done, div_by_zero, overflow;
  logic [7:0]  quotient, remainder;

  fxdiv16by8_seq #(.ERR_QUOT(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
    int         scyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient",    32'(quotient),    32'(e.q));
        chk("remainder",   32'(remainder),   32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("overflow",    32'(overflow),    32'(e.ovf));
        chk("latency",     32'(cyc - e.scyc + 1), 32'(e.lat));
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; failures++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push(input logic [7:0] q, input logic [7:0] r, input logic dbz,
                      input logic ovf, input int lat, input int scyc);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.scyc = scyc;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [15:0] dvd, input logic [7:0] dsr,
                       input logic [7:0] q, input logic [7:0] r,
                       input logic dbz, input logic ovf, input int lat);
    wait_idle();
    dividend = dvd;
    divisor  = dsr;
    start    = 1'b1;
    push(q, r, dbz, ovf, lat, cyc + 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),        32'd0);
    chk({tag, "_done"},  32'(done),        32'd0);
    chk({tag, "_quot"},  32'(quotient),    32'd0);
    chk({tag, "_rem"},   32'(remainder),   32'd0);
    chk({tag, "_dbz"},   32'(div_by_zero), 32'd0);
    chk({tag, "_ovf"},   32'(overflow),    32'd0);
  endtask

  initial begin
    #2;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First start right after release, then hold check
    issue(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 9);
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_quot", 32'(quotient),  32'h36);
    chk("hold_rem",  32'(remainder), 32'h10);
    chk("hold_busy", 32'(busy),      32'd0);

    issue(16'h3FC1, 8'h7F, 8'h80, 8'h41, 1'b0, 1'b0, 9);
    issue(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9);
    issue(16'h0000, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 9);
    issue(16'h5555, 8'h56, 8'hFE, 8'h01, 1'b0, 1'b0, 9);
    issue(16'h5600, 8'h56, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    issue(16'hFFFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
    issue(16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
    issue(16'h0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1);
    issue(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9);
    wait_done();

    // start during CALC with other operands is ignored
    issue(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 9);
    @(negedge clk);
    dividend = 16'h00FF; divisor = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 16'hFFFF; divisor = 8'h00;
    wait_done();
    repeat (3) @(negedge clk);
    chk("ignore_quot", 32'(quotient),  32'h36);
    chk("ignore_rem",  32'(remainder), 32'h10);

    // start held high: back-to-back with one IDLE cycle between
    wait_idle();
    dividend = 16'h5555; divisor = 8'h56; start = 1'b1;
    push(8'hFE, 8'h01, 1'b0, 1'b0, 9, cyc + 1);
    push(8'hFE, 8'h01, 1'b0, 1'b0, 9, cyc + 11);
    repeat (11) @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset at CALC cycle 4 aborts with no done pulse
    issue(16'h3FC1, 8'h7F, 8'h80, 8'h41, 1'b0, 1'b0, 9);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_reset_done", 32'(done), 32'd0);
    issue(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 9);
    wait_done();

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
